// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous signal over
// a fixed window of clk cycles and reports the count (saturating) once per gate.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; no counting
//   MEASURE  | gate open for GATE_CYCLES cycles, counting synchronized edges
//   DONE     | single cycle; freq/overflow just updated, freq_valid high
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;

    logic             sync1_q, sync2_q, hist_q;
    logic             strobe;
    logic [CNT_W-1:0] edge_nx;
    logic             sat_nx;

    // Two-flop synchronizer plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign strobe = sync2_q & ~hist_q;

    // Saturating edge-count increment; a strobe at full scale only flags overflow
    always_comb begin
        edge_nx = edge_q;
        sat_nx  = sat_q;
        if (strobe) begin
            if (edge_q == CNT_MAX) begin
                sat_nx = 1'b1;
            end else begin
                edge_nx = edge_q + 1'b1;
            end
        end
    end

    // Next-state logic; counters are cleared whenever a new gate opens
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_MEASURE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                edge_d = edge_nx;
                sat_d  = sat_nx;
                if (gate_q == GATE_LAST) begin
                    // The final gate cycle's strobe is included in the result
                    state_d = ST_DONE;
                    freq_d  = edge_nx;
                    ovf_d   = sat_nx;
                end else begin
                    gate_d = gate_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (CONTINUOUS || start) begin
                    state_d = ST_MEASURE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign freq_valid = (state_q == ST_DONE);
    assign freq       = freq_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three instances (32-bit one-shot, 4-bit one-shot,
// 32-bit continuous) share sig_in and rst_n. A timestamp model predicts busy,
// freq_valid, freq and overflow every cycle from the recorded input history.
module tb_freq_meter;

    localparam int G = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sig_in, start_a, start_b, start_c;
    logic        busy_a, busy_b, busy_c;
    logic        fv_a, fv_b, fv_c;
    logic        ov_a, ov_b, ov_c;
    logic [31:0] freq_a, freq_c;
    logic [3:0]  freq_b;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .CONTINUOUS(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_a),
        .busy(busy_a), .freq(freq_a), .freq_valid(fv_a), .overflow(ov_a));

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .CONTINUOUS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_b),
        .busy(busy_b), .freq(freq_b), .freq_valid(fv_b), .overflow(ov_b));

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_c),
        .busy(busy_c), .freq(freq_c), .freq_valid(fv_c), .overflow(ov_c));

    int total = 0;
    int bad   = 0;
    int k     = 0;
    bit hbuf [0:8191];

    // Reference model: t0 = posedge index at which the current gate opened (-1 idle)
    int     t0    [3] = '{-1, -1, -1};
    longint mfreq [3] = '{0, 0, 0};
    bit     movf  [3] = '{0, 0, 0};
    int     cw    [3] = '{32, 4, 32};
    bit     cc    [3] = '{1'b0, 1'b0, 1'b1};

    int sig_mode  = 0;
    bit sig_const = 1'b0;
    int per       = 10;
    int ph        = 0;
    int ks        = 0;

    function automatic bit hv(input int i);
        return (i < 0) ? 1'b0 : hbuf[i];
    endfunction

    task automatic check(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cycle=%0d observed=%0d expected=%0d", tag, d, k, obs, exp);
        end
    endtask

    // Rising edges of the sampled history, seen two cycles later by the counter
    task automatic model_update(input int d, input bit st);
        int     cnt;
        longint mx;
        if (!rst_n) begin
            t0[d]    = -1;
            mfreq[d] = 0;
            movf[d]  = 1'b0;
        end else if (t0[d] < 0) begin
            if (st) t0[d] = k;
        end else if (k == t0[d] + G + 1) begin
            t0[d] = (cc[d] || st) ? k : -1;
        end
        if (t0[d] >= 0 && k == t0[d] + G) begin
            cnt = 0;
            for (int m = t0[d]; m < t0[d] + G; m++)
                if (hv(m - 1) && !hv(m - 2)) cnt++;
            mx       = (longint'(1) << cw[d]) - 1;
            mfreq[d] = (cnt > mx) ? mx : longint'(cnt);
            movf[d]  = (cnt > mx);
        end
    endtask

    task automatic check_dut(input int d, input logic b, input logic v,
                             input logic [63:0] f, input logic o);
        bit act;
        act = (t0[d] >= 0);
        check("busy", d, {63'd0, b}, {63'd0, act});
        check("freq_valid", d, {63'd0, v}, {63'd0, (act && k == t0[d] + G)});
        check("freq", d, f, mfreq[d]);
        check("overflow", d, {63'd0, o}, {63'd0, movf[d]});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            case (sig_mode)
                0: sig_in = sig_const;
                1: begin
                    sig_in = (ph < per / 2);
                    ph = (ph + 1) % per;
                end
                default: sig_in = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk);
            k++;
            hbuf[k] = rst_n ? sig_in : 1'b0;
            model_update(0, start_a);
            model_update(1, start_b);
            model_update(2, start_c);
            @(negedge clk);
            check_dut(0, busy_a, fv_a, {32'd0, freq_a}, ov_a);
            check_dut(1, busy_b, fv_b, {60'd0, freq_b}, ov_b);
            check_dut(2, busy_c, fv_c, {32'd0, freq_c}, ov_c);
        end
    endtask

    task automatic pulse_a();
        start_a = 1'b1; step(1); start_a = 1'b0; ks = k;
    endtask

    initial begin
        // Reset held with sig toggling and start high: outputs stay quiet
        rst_n = 1'b0; sig_in = 1'b0;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        sig_mode = 1; per = 3; ph = 0;
        step(6);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(3);

        // Period 10, result exactly G+1 cycles after start sampled
        per = 10; ph = 0;
        step(20);
        pulse_a();
        step(G - 1);
        check("pre_valid", 0, {63'd0, fv_a}, 64'd0);
        step(1);
        check("valid_at_101", 0, {63'd0, fv_a}, 64'd1);
        check("freq_p10", 0, {32'd0, freq_a}, 64'd10);
        check("ovf_p10", 0, {63'd0, ov_a}, 64'd0);
        step(1);
        check("busy_after", 0, {63'd0, busy_a}, 64'd0);

        // Constant 0, constant 1, single mid-gate edge
        sig_mode = 0; sig_const = 1'b0;
        step(5); pulse_a(); step(G);
        check("freq_const0", 0, {32'd0, freq_a}, 64'd0);
        step(2);
        sig_const = 1'b1;
        step(10); pulse_a(); step(G);
        check("freq_const1", 0, {32'd0, freq_a}, 64'd0);
        step(2);
        sig_const = 1'b0;
        step(5); pulse_a(); step(40);
        sig_const = 1'b1;
        step(G - 40);
        check("freq_single", 0, {32'd0, freq_a}, 64'd1);
        step(2);

        // 4-bit counter saturates at 15 with 25 edges, then recovers
        sig_mode = 1; per = 4; ph = 0;
        step(10);
        start_b = 1'b1; step(1); start_b = 1'b0;
        step(G);
        check("freq_sat", 1, {60'd0, freq_b}, 64'd15);
        check("ovf_sat", 1, {63'd0, ov_b}, 64'd1);
        step(2);
        per = 10; ph = 0;
        step(10);
        start_b = 1'b1; step(1); start_b = 1'b0;
        step(G);
        check("freq_recover", 1, {60'd0, freq_b}, 64'd10);
        check("ovf_recover", 1, {63'd0, ov_b}, 64'd0);
        step(2);

        // Reset at gate cycle 50 abandons the measurement
        pulse_a(); step(50);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(G + 20);
        check("freq_after_rst", 0, {32'd0, freq_a}, 64'd0);
        check("idle_after_rst", 0, {63'd0, busy_a}, 64'd0);
        step(5); pulse_a(); step(G);
        check("freq_post_rst", 0, {32'd0, freq_a}, 64'd10);

        // Continuous mode, period 5, start pulses mid-gate must not disturb timing
        per = 5; ph = 0;
        step(10);
        start_c = 1'b1; step(1); start_c = 1'b0;
        step(G);
        check("cont_valid0", 2, {63'd0, fv_c}, 64'd1);
        check("cont_freq0", 2, {32'd0, freq_c}, 64'd20);
        for (int j = 0; j < 3; j++) begin
            step(30);
            start_c = 1'b1; step(1); start_c = 1'b0;
            step(G - 30);
            check("cont_valid", 2, {63'd0, fv_c}, 64'd1);
            check("cont_freq", 2, {32'd0, freq_c}, 64'd20);
        end

        // Randomized signal and start traffic against the model
        for (int r = 0; r < 1200; r++) begin
            if (r % 150 == 0) begin
                sig_mode = $urandom_range(1, 2);
                per = $urandom_range(2, 12);
                ph = 0;
            end
            start_a = ($urandom_range(0, 15) == 0);
            start_b = ($urandom_range(0, 15) == 0);
            start_c = ($urandom_range(0, 31) == 0);
            if (r == 700) begin
                rst_n = 1'b0;
                step(3);
                rst_n = 1'b1;
            end
            step(1);
        end
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        step(2 * G + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
